// File: rtl/gcd_job_sequencer.sv
// gcd_job_sequencer: queues operand pairs, feeds them one at a time to a GCD engine, returns results with timeout recovery
// Ports:
//   clk, reset_n                 clock and synchronous active-low reset
//   in_valid/in_ready/in_a/in_b  operand pair input handshake
//   gcd_a_in/gcd_b_in/gcd_start  job issued to the engine (operands held ISSUE..WAIT)
//   gcd_result/gcd_done          engine response, honoured only in WAIT
//   out_valid/out_ready          result output handshake
//   out_result/out_err           gcd value, and timeout flag (result forced to 0 on timeout)
//   busy, fifo_count             activity and FIFO occupancy status
module gcd_job_sequencer #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  output logic [WIDTH-1:0]         gcd_a_in,
  output logic [WIDTH-1:0]         gcd_b_in,
  output logic                     gcd_start,
  input  logic [WIDTH-1:0]         gcd_result,
  input  logic                     gcd_done,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_result,
  output logic                     out_err,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [TW-1:0] timer, timer_nx;
  logic [WIDTH-1:0] a_nx, b_nx, res_nx, head_a, head_b;
  logic err_nx, push, pop, timeout;
  // in_ready depends on the registered count only, so a same-cycle pop never reopens a full FIFO
  assign in_ready   = reset_n && (count < (AW+1)'(DEPTH));
  assign push       = in_valid && in_ready;
  assign pop        = (state == IDLE) && (count != '0);
  assign head_a     = mem_a[rd_ptr];
  assign head_b     = mem_b[rd_ptr];
  // compare the post-increment value so HOLD is reached exactly TIMEOUT cycles after the start strobe
  assign timeout    = (timer + TW'(1)) == TW'(TIMEOUT - 1);
  assign gcd_start  = state == ISSUE;
  assign out_valid  = state == HOLD;
  assign busy       = (state != IDLE) || (count != '0);
  assign fifo_count = count;
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end
  always_comb begin
    state_nx = state;
    a_nx     = gcd_a_in;
    b_nx     = gcd_b_in;
    res_nx   = out_result;
    err_nx   = out_err;
    timer_nx = timer;
    case (state)
      IDLE: if (pop) begin
        if (head_a == '0 || head_b == '0) begin
          state_nx = HOLD;
          res_nx   = head_a | head_b;
          err_nx   = 1'b0;
        end else begin
          state_nx = ISSUE;
          a_nx     = head_a;
          b_nx     = head_b;
        end
      end
      ISSUE: begin
        timer_nx = '0;
        state_nx = WAIT;
      end
      WAIT: begin
        timer_nx = timer + TW'(1);
        if (gcd_done) begin
          state_nx = HOLD;
          res_nx   = gcd_result;
          err_nx   = 1'b0;
        end else if (timeout) begin
          state_nx = HOLD;
          res_nx   = '0;
          err_nx   = 1'b1;
        end
      end
      HOLD: state_nx = out_ready ? IDLE : HOLD;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      gcd_a_in   <= '0;
      gcd_b_in   <= '0;
      out_result <= '0;
      out_err    <= 1'b0;
      timer      <= '0;
    end else begin
      state      <= state_nx;
      gcd_a_in   <= a_nx;
      gcd_b_in   <= b_nx;
      out_result <= res_nx;
      out_err    <= err_nx;
      timer      <= timer_nx;
    end
  end
endmodule
